// File: rtl/rv32_decode_stage.sv
// ---------------------------------------------------------------------------
// rv32_decode_stage
// RV32 instruction decode stage: one output register with a valid/ready
// handshake, 1-cycle latency and full 1-instruction-per-cycle throughput.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   flush                         drops the held bundle and any incoming word
//   in_valid / in_ready           upstream handshake (in_ready is combinational)
//   instruction, in_pc            raw instruction word and its PC
//   out_valid / out_ready         downstream handshake
//   out_pc                        registered PC
//   opcode rd funct3 rs1 rs2 funct7   raw field slices of the held word
//   imm [XLEN]                    sign-extended immediate
//   fmt                           R=0 I=1 S=2 B=3 U=4 J=5
//   uses_rs1 uses_rs2 writes_rd   operand-use flags
//   illegal                       instruction is illegal
//   decode_count, illegal_count   wrapping transfer statistics
// ---------------------------------------------------------------------------
module rv32_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned M_EXT = 0,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       funct7,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             uses_rs1,
    output logic             uses_rs2,
    output logic             writes_rd,
    output logic             illegal,
    output logic [CNT_W-1:0] decode_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam int unsigned IW = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MUL  = 7'h01;

    // ---------------------------------------------------------------
    // Combinational decode of the incoming word
    // ---------------------------------------------------------------
    logic [6:0]    opc_c;
    logic [6:0]    f7_c;
    logic [2:0]    f3_c;
    logic [4:0]    rd_idx_c;
    logic [IW-1:0] instr_c;

    assign instr_c  = instruction;
    assign opc_c    = instr_c[6:0];
    assign rd_idx_c = instr_c[11:7];
    assign f3_c     = instr_c[14:12];
    assign f7_c     = instr_c[31:25];

    logic [2:0]    fmt_c;
    logic [IW-1:0] imm32_c;
    logic          known_op_c;
    logic          m_ok_c;
    logic          r_bad_c;
    logic          jalr_bad_c;
    logic          illegal_c;
    logic          uses_rs1_c;
    logic          uses_rs2_c;
    logic          writes_rd_c;
    logic [XLEN-1:0] imm_c;

    // Opcode class, immediate assembly and legality checks
    always_comb begin
        fmt_c       = FMT_I;
        imm32_c     = '0;
        known_op_c  = 1'b1;
        m_ok_c      = 1'b0;
        r_bad_c     = 1'b0;
        jalr_bad_c  = 1'b0;
        illegal_c   = 1'b0;
        uses_rs1_c  = 1'b0;
        uses_rs2_c  = 1'b0;
        writes_rd_c = 1'b0;

        case (opc_c)
            OPC_OP:                                       fmt_c = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:   fmt_c = FMT_I;
            OPC_STORE:                                    fmt_c = FMT_S;
            OPC_BRANCH:                                   fmt_c = FMT_B;
            OPC_LUI, OPC_AUIPC:                           fmt_c = FMT_U;
            OPC_JAL:                                      fmt_c = FMT_J;
            default:                                      known_op_c = 1'b0;
        endcase

        case (fmt_c)
            FMT_I: imm32_c = {{20{instr_c[31]}}, instr_c[31:20]};
            FMT_S: imm32_c = {{20{instr_c[31]}}, instr_c[31:25], instr_c[11:7]};
            FMT_B: imm32_c = {{19{instr_c[31]}}, instr_c[31], instr_c[7],
                              instr_c[30:25], instr_c[11:8], 1'b0};
            FMT_U: imm32_c = {instr_c[31:12], 12'b0};
            FMT_J: imm32_c = {{11{instr_c[31]}}, instr_c[31], instr_c[19:12],
                              instr_c[20], instr_c[30:21], 1'b0};
            default: imm32_c = '0;
        endcase

        m_ok_c = (M_EXT != 0) && (f7_c == F7_MUL);

        // funct7 legality only constrains register-register ops; in I/S/B
        // formats those bits belong to the immediate.
        if (fmt_c == FMT_R) begin
            r_bad_c = !((f7_c == F7_BASE) || (f7_c == F7_ALT) || m_ok_c)
                   || ((f7_c == F7_ALT) && (f3_c != 3'b000) && (f3_c != 3'b101));
        end

        jalr_bad_c = (opc_c == OPC_JALR) && (f3_c != 3'b000);

        illegal_c = (instr_c[1:0] != 2'b11) || !known_op_c || r_bad_c || jalr_bad_c;

        // CSR immediate forms (funct3[2]=1) carry a zimm in the rs1 slot
        uses_rs1_c = ((fmt_c == FMT_R) || (fmt_c == FMT_I) ||
                      (fmt_c == FMT_S) || (fmt_c == FMT_B))
                  && !((opc_c == OPC_SYSTEM) && f3_c[2]);
        uses_rs2_c = (fmt_c == FMT_R) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
        writes_rd_c = ((fmt_c == FMT_R) || (fmt_c == FMT_I) ||
                       (fmt_c == FMT_U) || (fmt_c == FMT_J))
                   && (rd_idx_c != 5'd0);

        if (illegal_c) begin
            fmt_c       = FMT_I;
            imm32_c     = '0;
            uses_rs1_c  = 1'b0;
            uses_rs2_c  = 1'b0;
            writes_rd_c = 1'b0;
        end
    end

    // Sign extension from bit 31 to the configured register width
    assign imm_c = XLEN'($signed(imm32_c));

    // ---------------------------------------------------------------
    // Handshake and next-state
    // ---------------------------------------------------------------
    logic             valid_q, valid_d;
    logic [31:0]      pc_q;
    logic [IW-1:0]    instr_q;
    logic [XLEN-1:0]  imm_q;
    logic [2:0]       fmt_q;
    logic             uses_rs1_q;
    logic             uses_rs2_q;
    logic             writes_rd_q;
    logic             illegal_q;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic             accept_c;
    logic             xfer_c;

    assign in_ready = !valid_q || out_ready;
    assign accept_c = in_valid && in_ready && !flush && !reset;
    // A transfer concurrent with flush still counts
    assign xfer_c   = valid_q && out_ready;

    // Valid bit and statistics next-state; flush dominates handshake events
    always_comb begin
        valid_d   = valid_q;
        dec_cnt_d = dec_cnt_q;
        ill_cnt_d = ill_cnt_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_c) begin
            valid_d = 1'b1;
        end else if (xfer_c) begin
            valid_d = 1'b0;
        end

        if (xfer_c) begin
            dec_cnt_d = dec_cnt_q + CNT_W'(1);
            if (illegal_q) begin
                ill_cnt_d = ill_cnt_q + CNT_W'(1);
            end
        end
    end

    // Output register; bundle only loads on accept so it holds while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            instr_q     <= '0;
            imm_q       <= '0;
            fmt_q       <= '0;
            uses_rs1_q  <= 1'b0;
            uses_rs2_q  <= 1'b0;
            writes_rd_q <= 1'b0;
            illegal_q   <= 1'b0;
            dec_cnt_q   <= '0;
            ill_cnt_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            dec_cnt_q <= dec_cnt_d;
            ill_cnt_q <= ill_cnt_d;
            if (accept_c) begin
                pc_q        <= in_pc;
                instr_q     <= instr_c;
                imm_q       <= imm_c;
                fmt_q       <= fmt_c;
                uses_rs1_q  <= uses_rs1_c;
                uses_rs2_q  <= uses_rs2_c;
                writes_rd_q <= writes_rd_c;
                illegal_q   <= illegal_c;
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign opcode        = instr_q[6:0];
    assign rd            = instr_q[11:7];
    assign funct3        = instr_q[14:12];
    assign rs1           = instr_q[19:15];
    assign rs2           = instr_q[24:20];
    assign funct7        = instr_q[31:25];
    assign imm           = imm_q;
    assign fmt           = fmt_q;
    assign uses_rs1      = uses_rs1_q;
    assign uses_rs2      = uses_rs2_q;
    assign writes_rd     = writes_rd_q;
    assign illegal       = illegal_q;
    assign decode_count  = dec_cnt_q;
    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_rv32_decode_stage
// Directed scoreboard bench for rv32_decode_stage. The stimulus process pushes
// hand-computed expected bundles; monitors pop and compare on each transfer.
// A second instance with M_EXT=1 covers the multiply-extension legality.
// ---------------------------------------------------------------------------
module tb_rv32_decode_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        u1;
        logic        u2;
        logic        wr;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush;

    // Main instance (M_EXT=0)
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      instruction, in_pc, out_pc;
    logic [6:0]       opcode, funct7;
    logic [4:0]       rd, rs1, rs2;
    logic [2:0]       funct3, fmt;
    logic [XLEN-1:0]  imm;
    logic             uses_rs1, uses_rs2, writes_rd, illegal;
    logic [CNT_W-1:0] decode_count, illegal_count;

    // M_EXT=1 instance
    logic             m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [31:0]      m_instruction, m_in_pc, m_out_pc;
    logic [6:0]       m_opcode, m_funct7;
    logic [4:0]       m_rd, m_rs1, m_rs2;
    logic [2:0]       m_funct3, m_fmt;
    logic [XLEN-1:0]  m_imm;
    logic             m_uses_rs1, m_uses_rs2, m_writes_rd, m_illegal;
    logic [CNT_W-1:0] m_decode_count, m_illegal_count;

    rv32_decode_stage #(.XLEN(XLEN), .M_EXT(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .fmt(fmt),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .writes_rd(writes_rd),
        .illegal(illegal), .decode_count(decode_count), .illegal_count(illegal_count)
    );

    rv32_decode_stage #(.XLEN(XLEN), .M_EXT(1), .CNT_W(CNT_W)) dut_m (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .instruction(m_instruction), .in_pc(m_in_pc),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_pc(m_out_pc),
        .opcode(m_opcode), .rd(m_rd), .funct3(m_funct3), .rs1(m_rs1), .rs2(m_rs2),
        .funct7(m_funct7), .imm(m_imm), .fmt(m_fmt),
        .uses_rs1(m_uses_rs1), .uses_rs2(m_uses_rs2), .writes_rd(m_writes_rd),
        .illegal(m_illegal), .decode_count(m_decode_count), .illegal_count(m_illegal_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    exp_t q[$];
    exp_t qm[$];
    exp_t vec[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] im,
                                input logic [2:0] f, input logic u1, input logic u2,
                                input logic wr, input logic ill);
        exp_t e;
        e.pc = '0; e.instr = instr; e.imm = im; e.fmt = f;
        e.u1 = u1; e.u2 = u2; e.wr = wr; e.ill = ill;
        return e;
    endfunction

    // Main-instance monitor: compare every transfer against the scoreboard
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_transfer", 64'(out_pc), 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pc",       64'(out_pc),    64'(e.pc));
                chk("opcode",   64'(opcode),    64'(e.instr[6:0]));
                chk("rd",       64'(rd),        64'(e.instr[11:7]));
                chk("funct3",   64'(funct3),    64'(e.instr[14:12]));
                chk("rs1",      64'(rs1),       64'(e.instr[19:15]));
                chk("rs2",      64'(rs2),       64'(e.instr[24:20]));
                chk("funct7",   64'(funct7),    64'(e.instr[31:25]));
                chk("fmt",      64'(fmt),       64'(e.fmt));
                chk("imm",      64'(imm),       64'(e.imm));
                chk("uses_rs1", 64'(uses_rs1),  64'(e.u1));
                chk("uses_rs2", 64'(uses_rs2),  64'(e.u2));
                chk("writes_rd",64'(writes_rd), 64'(e.wr));
                chk("illegal",  64'(illegal),   64'(e.ill));
            end
        end
    end

    // M_EXT=1 instance monitor
    always @(negedge clk) begin
        if (!reset && m_out_valid && m_out_ready) begin
            if (qm.size() == 0) begin
                chk("m_unexpected_transfer", 64'(m_out_pc), 64'hDEAD);
            end else begin
                exp_t e;
                e = qm.pop_front();
                chk("m_pc",       64'(m_out_pc),    64'(e.pc));
                chk("m_rd",       64'(m_rd),        64'(e.instr[11:7]));
                chk("m_fmt",      64'(m_fmt),       64'(e.fmt));
                chk("m_imm",      64'(m_imm),       64'(e.imm));
                chk("m_uses_rs1", 64'(m_uses_rs1),  64'(e.u1));
                chk("m_uses_rs2", 64'(m_uses_rs2),  64'(e.u2));
                chk("m_writes_rd",64'(m_writes_rd), 64'(e.wr));
                chk("m_illegal",  64'(m_illegal),   64'(e.ill));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for one cycle; caller guarantees it will be accepted
    task automatic send(input int idx, input logic [31:0] pc);
        exp_t e;
        e = vec[idx];
        e.pc = pc;
        q.push_back(e);
        in_valid    = 1'b1;
        instruction = e.instr;
        in_pc       = pc;
        step();
        in_valid    = 1'b0;
    endtask

    task automatic send_m(input exp_t ex, input logic [31:0] pc);
        exp_t e;
        e = ex;
        e.pc = pc;
        qm.push_back(e);
        m_in_valid    = 1'b1;
        m_instruction = e.instr;
        m_in_pc       = pc;
        step();
        m_in_valid    = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((q.size() != 0 || qm.size() != 0) && cyc < 50) begin
            step();
            cyc++;
        end
        if (q.size() != 0 || qm.size() != 0)
            chk("drain_timeout", 64'(q.size() + qm.size()), 64'd0);
        step();
        step();
    endtask

    task automatic chk_cnt(input string nm, input int dec, input int ill);
        chk({nm, "_decode_count"},  64'(decode_count),  64'(dec));
        chk({nm, "_illegal_count"}, 64'(illegal_count), 64'(ill));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //               instr          imm           fmt  u1  u2  wr  ill
        vec[0]  = mk(32'h00500093, 32'h00000005, 3'd1, 1, 0, 1, 0); // addi x1,x0,5
        vec[1]  = mk(32'h00000000, 32'h00000000, 3'd1, 0, 0, 0, 1); // all zero
        vec[2]  = mk(32'h0200C0B3, 32'h00000000, 3'd1, 0, 0, 0, 1); // div w/o M
        vec[3]  = mk(32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1, 1, 0, 0); // sw x2,-4(x1)
        vec[4]  = mk(32'h123452B7, 32'h12345000, 3'd4, 0, 0, 1, 0); // lui x5
        vec[5]  = mk(32'h8000006F, 32'hFFF00000, 3'd5, 0, 0, 0, 0); // jal x0,-1M
        vec[6]  = mk(32'h80000063, 32'hFFFFF000, 3'd3, 1, 1, 0, 0); // beq -4096
        vec[7]  = mk(32'h000010E7, 32'h00000000, 3'd1, 0, 0, 0, 1); // jalr f3=1
        vec[8]  = mk(32'h00105073, 32'h00000001, 3'd1, 0, 0, 0, 0); // csrrwi x0
        vec[9]  = mk(32'h40208133, 32'h00000000, 3'd0, 1, 1, 1, 0); // sub x2
        vec[10] = mk(32'h40209133, 32'h00000000, 3'd1, 0, 0, 0, 1); // f7=20 f3=1
        vec[11] = mk(32'h0000007F, 32'h00000000, 3'd1, 0, 0, 0, 1); // bad opcode
        vec[12] = mk(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1, 0, 1, 0); // addi -1
        vec[13] = mk(32'h00000073, 32'h00000000, 3'd1, 1, 0, 0, 0); // ecall

        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; instruction = '0; in_pc = '0;
        m_in_valid = 1'b0; m_out_ready = 1'b1; m_instruction = '0; m_in_pc = '0;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_imm",       64'(imm),       64'd0);
        chk_cnt("rst", 0, 0);
        reset = 1'b0;
        step();

        // Single addi: 1-cycle latency then one counted transfer
        send(0, 32'h1000);
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        step();
        chk("after_xfer_out_valid", 64'(out_valid), 64'd0);
        chk_cnt("addi", 1, 0);

        // Two illegal words
        send(1, 32'h1004);
        send(2, 32'h1008);
        drain();
        chk_cnt("illegal_pair", 3, 2);

        // Same mul/div word is legal with the M extension
        send_m(mk(32'h0200C0B3, 32'h00000000, 3'd0, 1, 1, 1, 0), 32'h2000);
        send_m(vec[10], 32'h2004);
        drain();
        chk("m_decode_count",  64'(m_decode_count),  64'd2);
        chk("m_illegal_count", 64'(m_illegal_count), 64'd1);

        // Back-to-back stream of the remaining vectors
        for (int i = 3; i < 14; i++) send(i, 32'h3000 + 32'(i * 4));
        drain();
        chk_cnt("stream", 14, 5);

        // Stall: out_ready low for two cycles after the first accept
        out_ready = 1'b0;
        send(0, 32'h4000);
        begin
            exp_t e;
            e = vec[3]; e.pc = 32'h4004; q.push_back(e);
        end
        in_valid = 1'b1; instruction = vec[3].instr; in_pc = 32'h4004;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("stall_in_ready",  64'(in_ready),  64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_pc",        64'(out_pc),    64'h4000);
            chk("stall_imm",       64'(imm),       64'd5);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        send(4, 32'h4008);
        drain();
        chk_cnt("stall", 17, 5);

        // Flush while holding an untransferred bundle with a new word pending
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = vec[5].instr; in_pc = 32'h5000;
        step();
        instruction = vec[6].instr; in_pc = 32'h5004; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        step();
        chk("flush_out_valid2", 64'(out_valid), 64'd0);
        chk_cnt("flush", 17, 5);

        // Transfer coinciding with flush still counts
        out_ready = 1'b1;
        send(9, 32'h6000);
        flush = 1'b1; in_valid = 1'b1; instruction = vec[1].instr; in_pc = 32'h6004;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_xfer_out_valid", 64'(out_valid), 64'd0);
        step();
        chk_cnt("flush_xfer", 18, 5);

        // Reset asserted mid-stall discards the held word
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = vec[0].instr; in_pc = 32'h7000;
        step();
        instruction = vec[3].instr; in_pc = 32'h7004; reset = 1'b1;
        step();
        chk("rst_stall_out_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_in_ready",  64'(in_ready),  64'd1);
        chk_cnt("rst_stall", 0, 0);
        step();
        reset = 1'b0; in_valid = 1'b0;
        chk("rst_no_accept", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        step();

        // Counting resumes from zero after reset
        send(12, 32'h8000);
        send(11, 32'h8004);
        drain();
        chk_cnt("post_rst", 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_decode_stage.md
RV32_DECODE_STAGE -- requirements
Module: rv32_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, sets the immediate width; legal values are 32 and 64, and the immediate is sign-extended to XLEN.
REQ-002 Parameter M_EXT, default 0; when 1, R-type funct7=0x01 is legal.
REQ-003 Parameter CNT_W, default 32, sets the width of the statistics counters.
REQ-004 The block SHALL provide these ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  drops the held and incoming instruction.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- instruction  in  32  raw instruction word.
- in_pc  in  32  PC of the instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  32  registered PC.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- imm  out  XLEN  sign-extended immediate.
- fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5.
- uses_rs1, uses_rs2, writes_rd  out  1 each  operand-use flags.
- illegal  out  1  instruction is illegal.
- decode_count  out  CNT_W  number of output transfers.
- illegal_count  out  CNT_W  number of illegal output transfers.

Function
REQ-005 The stage SHALL be a single output register with a valid/ready handshake.
REQ-006 in_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-007 An input is accepted on a cycle with in_valid && in_ready && !flush; the decoded bundle appears on the next cycle with out_valid=1, giving 1-cycle latency.
REQ-008 When out_valid && !out_ready, every output SHALL hold stable; back-to-back accepts SHALL sustain 1 instruction per cycle.
REQ-009 An output transfer is out_valid && out_ready; on a transfer with no new accept, out_valid SHALL go to 0 on the next cycle.
REQ-010 When flush=1, out_valid SHALL go to 0 on the next cycle, any concurrent input is not accepted, and flush SHALL take priority over every handshake event.
REQ-011 A transfer occurring in the same cycle as flush SHALL still count as a transfer.
REQ-012 fmt decode by opcode:
- 0110011 -> R.
- 0010011, 0000011, 1100111, 1110011 -> I.
- 0100011 -> S.
- 1100011 -> B.
- 0110111, 0010111 -> U.
- 1101111 -> J.
REQ-013 imm construction by fmt:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- All of the above are sign-extended from instr[31] to XLEN; R gives imm=0.
REQ-014 uses_rs1=1 for R, I, S and B, except when opcode=1110011 and funct3[2]=1.
REQ-015 uses_rs2=1 for R, S and B.
REQ-016 writes_rd=1 for R, I, U and J only when rd!=0; S, B, illegal instructions and rd=0 give writes_rd=0.
REQ-017 illegal=1 if any of the following holds:
- instr[1:0]!=11.
- opcode is not in the REQ-012 list.
- R-type funct7 is not 0x00, 0x20 or (M_EXT=1 and 0x01).
- funct7=0x20 with funct3 not in {000, 101}.
- opcode 1100111 with funct3!=000.
REQ-018 When illegal=1, fmt SHALL be I and the imm, uses and writes flags SHALL all be 0.
REQ-019 Field outputs (opcode, rd, funct3, rs1, rs2, funct7) SHALL be raw bit slices regardless of fmt or illegal.
REQ-020 decode_count SHALL increment on each transfer; illegal_count SHALL increment on each transfer with illegal=1.
REQ-021 Both counters SHALL wrap modulo 2^CNT_W and are not cleared by flush.

Reset
REQ-022 While reset=1 at a clock edge, out_valid, both counters and all registered bundle fields SHALL be 0 on the next cycle.
REQ-023 During reset, in_ready SHALL evaluate as 1 per REQ-006, but no input is accepted while reset=1.
REQ-024 Reset asserted mid-stall SHALL discard the held instruction without counting it.

Verification
REQ-025 Bench: instruction=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle: fmt=1, rd=1, rs1=0, imm=5, writes_rd=1, uses_rs2=0, illegal=0, decode_count=1.
REQ-026 Bench: 0xFE20AE23 (sw x2,-4(x1)) -> fmt=2, imm=0xFFFFFFFC, rs1=1, rs2=2, writes_rd=0; then 0x123452B7 (lui x5,0x12345) -> fmt=4, imm=0x12345000, rd=5.
REQ-027 Bench: 0x00000000, then 0x0200C0B3 with M_EXT=0 -> illegal=1 both times, illegal_count=2; the same word with M_EXT=1 -> illegal=0.
REQ-028 Bench: stream 3 instructions with out_ready=0 for 2 cycles after the first -> in_ready=0 and outputs stable while stalled, then all 3 delivered in order, decode_count=3.
REQ-029 Bench: flush coincident with in_valid while holding an untransferred bundle -> out_valid=0 next cycle, neither instruction emitted, counters unchanged.
REQ-030 Bench: reset asserted during a stall -> out_valid=0 and counters=0 on the following cycle.
